keycode_arbiter: RTL and testbench

Producer side of the single-byte `keycode` bus consumed by the ball/sprite motion logic. It takes raw USB HID boot-keyboard reports (modifier byte + six key slots) and reduces them to one stable "active" keycode per frame. It applies most-recent-press priority, stale-report timeout, and hold/auto-repeat tracking. It sits between the USB host software register interface and every frame-rate consumer of `keycode`.

---
 rtl/keycode_pkg.sv | 40 ++++
 rtl/hid_report_diff.sv | 39 +++
 rtl/keycode_arbiter.sv | 170 +++++++++++++++++
 tb/tb_keycode_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode arbiter.
// HID keycodes, six-slot report type, arbiter FSM states, slot helpers.
package keycode_pkg;

    localparam logic [7:0] KEY_NONE         = 8'h00;
    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_ERR_POST     = 8'h02;
    localparam logic [7:0] KEY_ERR_UNDEF    = 8'h03;
    localparam logic [7:0] KEY_A            = 8'h04;
    localparam logic [7:0] KEY_D            = 8'h07;
    localparam logic [7:0] KEY_S            = 8'h16;
    localparam logic [7:0] KEY_W            = 8'h1A;

    typedef logic [5:0][7:0] hid_slots_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } karb_state_t;

    function automatic logic is_err_code(input logic [7:0] c);
        return (c == KEY_ERR_ROLLOVER) ||
               (c == KEY_ERR_POST) ||
               (c == KEY_ERR_UNDEF);
    endfunction

    function automatic logic slot_hit(
        input logic [7:0] code,
        input hid_slots_t slots
    );
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (slots[j] == code) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/hid_report_diff.sv
// Combinational comparison of a HID report against the previous one.
// Ports: cur_keys/prev_keys/keycode in; error, new_valid, new_code,
// still_held, first_code out.
module hid_report_diff
    import keycode_pkg::*;
(
    input  hid_slots_t  cur_keys,
    input  hid_slots_t  prev_keys,
    input  logic [7:0]  keycode,
    output logic        error,
    output logic        new_valid,
    output logic [7:0]  new_code,
    output logic        still_held,
    output logic [7:0]  first_code
);

    // Walk from the top slot down so the lowest index ends up winning;
    // duplicate values collapse to their lowest slot for free.
    always_comb begin
        error      = 1'b0;
        new_valid  = 1'b0;
        new_code   = KEY_NONE;
        still_held = 1'b0;
        first_code = KEY_NONE;
        for (int i = 5; i >= 0; i--) begin
            if (is_err_code(cur_keys[i])) error = 1'b1;
            if (cur_keys[i] != KEY_NONE) begin
                first_code = cur_keys[i];
                if (!slot_hit(cur_keys[i], prev_keys)) begin
                    new_valid = 1'b1;
                    new_code  = cur_keys[i];
                end
            end
            if ((keycode != KEY_NONE) && (cur_keys[i] == keycode))
                still_held = 1'b1;
        end
    end

endmodule

// File: rtl/keycode_arbiter.sv
// Reduces HID boot-keyboard reports to one active keycode per frame,
// with newest-press priority, stale-report timeout and auto-repeat.
// Ports: Reset, frame_clk, report_valid/mod/keys in;
// keycode, modifier, key_new, key_repeat, hold_frames out.
module keycode_arbiter
    import keycode_pkg::*;
#(
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_PERIOD  = 6,
    parameter int TIMEOUT_FRAMES = 60
) (
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        report_valid,
    input  logic [7:0]  report_mod,
    input  logic [47:0] report_keys,
    output logic [7:0]  keycode,
    output logic [7:0]  modifier,
    output logic        key_new,
    output logic        key_repeat,
    output logic [7:0]  hold_frames
);

    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_FRAMES);
    localparam logic [7:0] RD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RP = 8'(REPEAT_PERIOD);

    logic [7:0]  r_keycode;
    logic [7:0]  r_modifier;
    logic        r_key_new;
    logic        r_key_repeat;
    logic [7:0]  r_hold;
    hid_slots_t  r_prev;
    logic [TW-1:0] r_to;
    logic [7:0]  r_rpt;
    karb_state_t r_state;

    hid_slots_t  w_keys;
    logic        w_error;
    logic        w_new_valid;
    logic [7:0]  w_new_code;
    logic        w_still_held;
    logic [7:0]  w_first_code;
    logic        w_accept;
    logic [TW-1:0] w_to_inc;
    logic        w_timeout;
    logic [7:0]  w_kc_nxt;
    logic        w_new_pulse;
    logic [7:0]  w_rpt_inc;
    logic [7:0]  w_rpt_nxt;
    logic        w_rpt_pulse;
    karb_state_t w_state_nxt;
    logic [7:0]  w_hold_nxt;

    assign w_keys = report_keys;

    hid_report_diff u_diff (
        .cur_keys   (w_keys),
        .prev_keys  (r_prev),
        .keycode    (r_keycode),
        .error      (w_error),
        .new_valid  (w_new_valid),
        .new_code   (w_new_code),
        .still_held (w_still_held),
        .first_code (w_first_code)
    );

    assign w_accept  = report_valid && !w_error;
    assign w_to_inc  = (r_to == TO_MAX) ? r_to : r_to + TW'(1);
    // A report in the firing cycle wins, since valid blocks the timeout.
    assign w_timeout = !report_valid && (w_to_inc == TO_MAX);

    always_comb begin
        w_kc_nxt = r_keycode;
        if (w_accept) begin
            if (w_new_valid)       w_kc_nxt = w_new_code;
            else if (w_still_held) w_kc_nxt = r_keycode;
            else                   w_kc_nxt = w_first_code;
        end else if (w_timeout) begin
            w_kc_nxt = KEY_NONE;
        end
    end

    // Only a freshly pressed key counts as new; falling back to an
    // older key that is still down is not a new press.
    assign w_new_pulse = w_accept && w_new_valid &&
                         (w_new_code != r_keycode);

    assign w_rpt_inc = r_rpt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt;
        w_rpt_pulse = 1'b0;
        if (w_kc_nxt == KEY_NONE) begin
            w_state_nxt = IDLE;
            w_rpt_nxt   = 8'd0;
        end else if (w_kc_nxt != r_keycode) begin
            w_state_nxt = DELAY;
            w_rpt_nxt   = 8'd0;
        end else begin
            unique case (r_state)
                DELAY: begin
                    if (w_rpt_inc == RD) begin
                        w_rpt_pulse = 1'b1;
                        w_rpt_nxt   = 8'd0;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_rpt_nxt = w_rpt_inc;
                    end
                end
                REPEAT: begin
                    if (w_rpt_inc == RP) begin
                        w_rpt_pulse = 1'b1;
                        w_rpt_nxt   = 8'd0;
                    end else begin
                        w_rpt_nxt = w_rpt_inc;
                    end
                end
                default: begin
                    w_state_nxt = DELAY;
                    w_rpt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_hold_nxt = 8'd0;
        if ((w_kc_nxt != KEY_NONE) && (w_kc_nxt == r_keycode))
            w_hold_nxt = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_keycode    <= KEY_NONE;
            r_modifier   <= 8'd0;
            r_key_new    <= 1'b0;
            r_key_repeat <= 1'b0;
            r_hold       <= 8'd0;
            r_prev       <= '0;
            r_to         <= '0;
            r_rpt        <= 8'd0;
            r_state      <= IDLE;
        end else begin
            r_keycode    <= w_kc_nxt;
            r_key_new    <= w_new_pulse;
            r_key_repeat <= w_rpt_pulse;
            r_hold       <= w_hold_nxt;
            r_rpt        <= w_rpt_nxt;
            r_state      <= w_state_nxt;
            if (w_accept) begin
                r_prev     <= w_keys;
                r_modifier <= report_mod;
                r_to       <= '0;
            end else if (!report_valid) begin
                r_to <= w_to_inc;
                if (w_timeout) r_prev <= '0;
            end
        end
    end

    assign keycode     = r_keycode;
    assign modifier    = r_modifier;
    assign key_new     = r_key_new;
    assign key_repeat  = r_key_repeat;
    assign hold_frames = r_hold;

endmodule

// File: tb/tb_keycode_arbiter.sv
// Scoreboard bench for keycode_arbiter: directed reports with
// hand-derived expectations queued per edge and checked by a monitor.
module tb_keycode_arbiter;
    import keycode_pkg::*;

    logic        Reset;
    logic        frame_clk;
    logic        report_valid;
    logic [7:0]  report_mod;
    hid_slots_t  report_keys;
    logic [7:0]  keycode;
    logic [7:0]  modifier;
    logic        key_new;
    logic        key_repeat;
    logic [7:0]  hold_frames;

    keycode_arbiter #(
        .REPEAT_DELAY   (30),
        .REPEAT_PERIOD  (6),
        .TIMEOUT_FRAMES (60)
    ) dut (
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .report_valid (report_valid),
        .report_mod   (report_mod),
        .report_keys  (report_keys),
        .keycode      (keycode),
        .modifier     (modifier),
        .key_new      (key_new),
        .key_repeat   (key_repeat),
        .hold_frames  (hold_frames)
    );

    typedef struct {
        int         cyc;
        logic [7:0] kc;
        logic [7:0] md;
        logic       kn;
        logic       kr;
        logic       krc;
        logic [7:0] hf;
        bit [95:0]  nm;
    } exp_t;

    exp_t q[$];
    int   ecnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) ecnt <= ecnt + 1;

    function automatic hid_slots_t ks(
        input logic [7:0] s0 = 8'h00, input logic [7:0] s1 = 8'h00,
        input logic [7:0] s2 = 8'h00, input logic [7:0] s3 = 8'h00,
        input logic [7:0] s4 = 8'h00, input logic [7:0] s5 = 8'h00
    );
        hid_slots_t s;
        s[0] = s0; s[1] = s1; s[2] = s2;
        s[3] = s3; s[4] = s4; s[5] = s5;
        return s;
    endfunction

    // Repeat pulse k frames after the press: first at 30, then every 6.
    function automatic logic rp(input int k);
        return (k >= 30) && (((k - 30) % 6) == 0);
    endfunction

    task automatic push(
        input int cyc, input logic [7:0] ekc, input logic [7:0] emd,
        input logic ekn, input logic ekr, input logic ekrc,
        input logic [7:0] ehf, input bit [95:0] nm
    );
        exp_t e;
        e.cyc = cyc; e.kc = ekc; e.md = emd; e.kn = ekn;
        e.kr = ekr; e.krc = ekrc; e.hf = ehf; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(
        input logic v, input logic [7:0] m, input hid_slots_t k,
        input logic [7:0] ekc, input logic [7:0] emd,
        input logic ekn, input logic ekr, input logic ekrc,
        input logic [7:0] ehf, input bit [95:0] nm
    );
        push(ecnt + 1, ekc, emd, ekn, ekr, ekrc, ehf, nm);
        report_valid = v;
        report_mod   = m;
        report_keys  = k;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic drain();
        exp_t e;
        logic ok;
        while (q.size() > 0 && q[0].cyc <= ecnt) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < ecnt) begin
                n_bad++;
                $display("FAIL %0s: missed check slot %0d (now %0d)",
                         e.nm, e.cyc, ecnt);
            end else begin
                ok = (keycode === e.kc) && (modifier === e.md) &&
                     (key_new === e.kn) && (hold_frames === e.hf) &&
                     (!e.krc || (key_repeat === e.kr));
                if (!ok) begin
                    n_bad++;
                    $display({"FAIL %0s @%0d: got kc=%h md=%h kn=%b",
                              " kr=%b hf=%0d want kc=%h md=%h kn=%b",
                              " kr=%b(chk %b) hf=%0d"},
                             e.nm, ecnt, keycode, modifier, key_new,
                             key_repeat, hold_frames, e.kc, e.md, e.kn,
                             e.kr, e.krc, e.hf);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge frame_clk or chk_ev);
            drain();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, %0d checks pending",
                 q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        report_valid = 1'b0;
        report_mod   = 8'h00;
        report_keys  = ks();
        @(posedge frame_clk);
        #1;
        step(1, 8'hAA, ks(8'h1A), 8'h00, 8'h00, 0, 0, 1, 0, "rst_a");
        step(0, 8'h00, ks(), 8'h00, 8'h00, 0, 0, 1, 0, "rst_b");
        Reset = 1'b0;

        // press W, then hold for 40 frames
        step(1, 8'h02, ks(8'h1A), 8'h1A, 8'h02, 1, 0, 1, 0, "t1_press");
        for (int k = 1; k <= 40; k++)
            step(1, 8'h02, ks(8'h1A), 8'h1A, 8'h02, 0, rp(k), 1,
                 8'(k), "t1_hold");

        // newer key takes over, fall back, release
        step(1, 8'h00, ks(8'h1A, 8'h07), 8'h07, 8'h00, 1, 0, 1, 0,
             "t2_newer");
        step(1, 8'h00, ks(8'h1A), 8'h1A, 8'h00, 0, 0, 1, 0, "t2_back");
        step(1, 8'h00, ks(), 8'h00, 8'h00, 0, 0, 1, 0, "t2_clear");
        step(1, 8'h00, ks(), 8'h00, 8'h00, 0, 0, 1, 0, "t2_idle");

        // lowest new slot, rejected reports, duplicates
        step(1, 8'h11, ks(8'h04, 8'h16), 8'h04, 8'h11, 1, 0, 1, 0,
             "t3_lowest");
        step(1, 8'h22, ks(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01),
             8'h04, 8'h11, 0, 0, 1, 1, "t3_reject");
        step(1, 8'h33, ks(8'h04, 8'h16), 8'h04, 8'h33, 0, 0, 1, 2,
             "t3_prevkept");
        step(1, 8'h44, ks(8'h04, 8'h16, 8'h03), 8'h04, 8'h33, 0, 0, 1,
             3, "t3_err03");
        step(1, 8'h55, ks(8'h04, 8'h16, 8'h2C, 8'h2C), 8'h2C, 8'h55,
             1, 0, 1, 0, "t3_dup");

        // fallback to S, then starve for 60 frames
        step(1, 8'h66, ks(8'h16), 8'h16, 8'h66, 0, 0, 1, 0, "t4_fallbk");
        for (int k = 1; k <= 60; k++)
            step(0, 8'h00, ks(), (k == 60) ? 8'h00 : 8'h16, 8'h66, 0,
                 (k == 60) ? 1'b0 : rp(k), 1,
                 (k == 60) ? 8'd0 : 8'(k), "t4_timeout");
        step(1, 8'h77, ks(8'h16), 8'h16, 8'h77, 1, 0, 1, 0, "t4_prevclr");
        for (int k = 1; k <= 59; k++)
            step(0, 8'h00, ks(), 8'h16, 8'h77, 0, rp(k), 1, 8'(k),
                 "t4_starve");
        step(1, 8'h77, ks(8'h16), 8'h16, 8'h77, 0, rp(60), 1, 60,
             "t4_rescue");
        step(0, 8'h00, ks(), 8'h16, 8'h77, 0, rp(61), 1, 61, "t4_after");

        // long hold saturates hold_frames
        step(1, 8'h88, ks(), 8'h00, 8'h88, 0, 0, 1, 0, "t5_clear");
        step(1, 8'h88, ks(8'h1A), 8'h1A, 8'h88, 1, 0, 1, 0, "t5_press");
        for (int k = 1; k <= 299; k++)
            step(1, 8'h88, ks(8'h1A), 8'h1A, 8'h88, 0, rp(k), 1,
                 (k > 255) ? 8'd255 : 8'(k), "t5_sat");

        // asynchronous reset mid-hold
        @(negedge frame_clk);
        #1;
        Reset = 1'b1;
        #1;
        push(ecnt, 8'h00, 8'h00, 0, 0, 1, 0, "rst_async");
        -> chk_ev;
        #1;
        @(posedge frame_clk);
        #1;
        step(1, 8'hAB, ks(8'h1A), 8'h00, 8'h00, 0, 0, 1, 0, "rst_hold");
        Reset = 1'b0;
        step(1, 8'h99, ks(8'h1A), 8'h1A, 8'h99, 1, 0, 1, 0, "t6_rstnew");
        step(1, 8'h99, ks(8'h1A), 8'h1A, 8'h99, 0, 0, 1, 1, "t6_hold");

        report_valid = 1'b0;
        for (int w = 0; w < 5 && q.size() > 0; w++)
            @(posedge frame_clk);
        @(negedge frame_clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d checks left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
